dual_path_pc_ctrl: RTL and testbench
====================================

# dual_path_pc_ctrl

Fetch-side PC controller for the dual-issue, dual-path core. It holds the fetch PC of the taken pipe (t) and the not-taken pipe (n), forks them onto separate paths when decode reports a branch, and re-converges them on the redirects issued by the branch control stage. It sits directly downstream of branch control, consuming its correct_en/correction outputs, and drives the instruction-memory address of both pipes.

## Interface
- PC_W, 10: PC width; word-addressed, wraps modulo 2^PC_W.
- RESET_PC, 0: PC value loaded into both pipes on reset.
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  global fetch stall; holds both PCs
- fork_req  in  1  decode holds a branch in either slot, present in both pipes
- fork_bta  in  PC_W  branch target of the decode branch
- correct_en_t  in  1  redirect the t pipe
- correction_t  in  PC_W  redirect target for the t pipe
- correct_en_n  in  1  redirect the n pipe
- correction_n  in  PC_W  redirect target for the n pipe
- pc_t  out  PC_W  t-pipe fetch PC (registered)
- pc_n  out  PC_W  n-pipe fetch PC (registered)
- forked  out  1  1 = pipes on divergent paths (state FORKED)
- fork_cnt  out  CNT_W  accepted forks, saturating
- corr_cnt  out  CNT_W  applied redirect events, saturating
- err  out  1  sticky protocol-violation flag

## Operation
- Two states, SINGLE and FORKED. `forked` = (state == FORKED).
- Dual issue: the default per-pipe update is PC + 2, modulo 2^PC_W. Example: 1022 → 0 at PC_W = 10.
- Per-pipe update priority: correction > fork > stall hold > +2.
- **Correction.** correct_en_t loads pc_t ← correction_t, and correct_en_n loads pc_n ← correction_n. This applies regardless of stall. State → SINGLE. The pipe that is not redirected follows the normal rules (+2, or hold if stalled).
- **Both correct_en same cycle.**
  - Both loads are applied and state → SINGLE.
  - err ← 1.
  - corr_cnt increments once.
- **Fork, in SINGLE.** When fork_req is high and stall is low:
  - pc_t ← fork_bta.
  - pc_n ← pc_n + 2 (fall-through).
  - State → FORKED; fork_cnt + 1.
- **Fork, in FORKED.** fork_req is ignored. Branch-in-branch is resolved by branch control via corrections.
- **Fork during stall.** fork_req is not sampled while stall = 1; decode holds it until stall drops.
- **Correction and fork same cycle.** The correction wins, the fork is dropped, state → SINGLE, and fork_cnt is unchanged.
- **Counters.** corr_cnt + 1 on any cycle where either correct_en is high. Both counters saturate at 2^CNT_W − 1.
- **err.** Set by a simultaneous dual correction. Cleared only by reset.

## Timing
- Reset (async, rst = 0):
  - pc_t = pc_n = RESET_PC.
  - State SINGLE, so forked = 0.
  - fork_cnt = corr_cnt = 0; err = 0.
  - Outputs take these values immediately on rst assertion and hold them until the first clk edge after release.
- All outputs are registered. A fork or correction sampled at edge k is visible on pc_t/pc_n/forked after edge k; there is no combinational path from inputs to outputs.
- correct_en_* is expected as a single-cycle pulse. If it is held high, the load repeats each cycle and corr_cnt increments each cycle.
- Reset asserted mid-FORKED aborts the fork with no residual state.

## Test plan
- **Reset and run.** Release rst, no stimulus, 4 cycles → pc_t = pc_n = 0, 2, 4, 6, 8; forked = 0; counters 0.
- **Fork.** At pc = 8, fork_req = 1, fork_bta = 100 for one cycle → next cycle pc_t = 100, pc_n = 10, forked = 1, fork_cnt = 1. A further fork_req while FORKED leaves fork_cnt = 1.
- **Taken resolution.** In FORKED with pc_t = 104, pc_n = 14, pulse correct_en_n with correction_n = 102 → next pc_n = 102, pc_t = 106, forked = 0, corr_cnt = 1.
- **Stall vs. correction.** stall = 1 with fork_req = 1 → PCs hold, no fork. Then with stall still 1, correct_en_t with correction_t = 40 → pc_t = 40, pc_n held.
- **Simultaneous events.**
  - correct_en_n with fork_req in the same cycle → correction applied, fork dropped, fork_cnt unchanged.
  - Both correct_en high → both loads applied, err = 1 and it stays 1 until rst.
- **Wrap and saturation.**
  - PC_W = 10, PCs at 1022 → next 0.
  - Force 2^CNT_W + 3 corrections (CNT_W = 4 in the bench) → corr_cnt stays at 15.
  - Async reset mid-FORKED → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/dual_path_pc_ctrl.sv
// dual_path_pc_ctrl
//   Fetch-side PC controller for the dual-issue, dual-path core. Holds the
//   fetch PC of the taken (t) and not-taken (n) pipes, forks them when decode
//   reports a branch, and re-converges them on branch-control redirects.
//
//   State table
//     SINGLE | both pipes follow the same control path; forks are accepted
//     FORKED | pipes on divergent paths; forks ignored until a redirect
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active-low
//   stall         global fetch stall, holds both PCs
//   fork_req      decode holds a branch (sampled only when stall = 0)
//   fork_bta      branch target of the decode branch
//   correct_en_t  redirect the t pipe to correction_t
//   correct_en_n  redirect the n pipe to correction_n
//   pc_t, pc_n    registered fetch PCs
//   forked        1 while in FORKED
//   fork_cnt      accepted forks, saturating
//   corr_cnt      cycles with any redirect, saturating
//   err           sticky: both redirects in the same cycle
module dual_path_pc_ctrl #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             fork_req,
  input  logic [PC_W-1:0]  fork_bta,
  input  logic             correct_en_t,
  input  logic [PC_W-1:0]  correction_t,
  input  logic             correct_en_n,
  input  logic [PC_W-1:0]  correction_n,
  output logic [PC_W-1:0]  pc_t,
  output logic [PC_W-1:0]  pc_n,
  output logic             forked,
  output logic [CNT_W-1:0] fork_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic             err
);

  typedef enum logic {
    SINGLE = 1'b0,
    FORKED = 1'b1
  } state_t;

  localparam logic [PC_W-1:0] PC_INC   = PC_W'(2);
  localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_t_nxt, pc_n_nxt;
  logic              any_corr;
  logic              fork_take;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= SINGLE;
      pc_t     <= PC_RESET;
      pc_n     <= PC_RESET;
      fork_cnt <= '0;
      corr_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_t  <= pc_t_nxt;
      pc_n  <= pc_n_nxt;
      if (fork_take && (fork_cnt != '1)) fork_cnt <= fork_cnt + 1'b1;
      if (any_corr && (corr_cnt != '1)) corr_cnt <= corr_cnt + 1'b1;
      if (correct_en_t && correct_en_n) err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    any_corr  = correct_en_t | correct_en_n;
    // A redirect in the same cycle kills the fork outright.
    fork_take = (state == SINGLE) && fork_req && !stall && !any_corr;

    pc_t_nxt = stall ? pc_t : pc_t + PC_INC;
    pc_n_nxt = stall ? pc_n : pc_n + PC_INC;

    if (correct_en_t)   pc_t_nxt = correction_t;
    else if (fork_take) pc_t_nxt = fork_bta;

    // The n pipe takes the fall-through on a fork, which is its +2 path.
    if (correct_en_n)   pc_n_nxt = correction_n;

    if (any_corr)       state_nxt = SINGLE;
    else if (fork_take) state_nxt = FORKED;
  end

  assign forked = (state == FORKED);

endmodule

// File: tb/tb_dual_path_pc_ctrl.sv
module tb_dual_path_pc_ctrl;

  localparam int PC_W  = 10;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             fork_req;
  logic [PC_W-1:0]  fork_bta;
  logic             correct_en_t;
  logic [PC_W-1:0]  correction_t;
  logic             correct_en_n;
  logic [PC_W-1:0]  correction_n;
  logic [PC_W-1:0]  pc_t;
  logic [PC_W-1:0]  pc_n;
  logic             forked;
  logic [CNT_W-1:0] fork_cnt;
  logic [CNT_W-1:0] corr_cnt;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  dual_path_pc_ctrl #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .fork_req     (fork_req),
    .fork_bta     (fork_bta),
    .correct_en_t (correct_en_t),
    .correction_t (correction_t),
    .correct_en_n (correct_en_n),
    .correction_n (correction_n),
    .pc_t         (pc_t),
    .pc_n         (pc_n),
    .forked       (forked),
    .fork_cnt     (fork_cnt),
    .corr_cnt     (corr_cnt),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pcs(input string tag, input int et, input int en, input logic ef);
    check({tag, " pc_t"}, 32'(pc_t), 32'(et));
    check({tag, " pc_n"}, 32'(pc_n), 32'(en));
    check({tag, " forked"}, 32'(forked), 32'(ef));
  endtask

  task automatic clear_inputs();
    stall = 0; fork_req = 0; fork_bta = '0;
    correct_en_t = 0; correction_t = '0;
    correct_en_n = 0; correction_n = '0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_pcs(tag, 0, 0, 1'b0);
    check({tag, " fork_cnt"}, 32'(fork_cnt), 0);
    check({tag, " corr_cnt"}, 32'(corr_cnt), 0);
    check({tag, " err"}, 32'(err), 0);
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    #3;
    check_reset_vals("reset");
    #4 rst = 1;
    #1;
    check_pcs("release", 0, 0, 1'b0);

    // Free run
    for (int i = 1; i <= 4; i++) begin
      step();
      check_pcs($sformatf("run%0d", i), 2 * i, 2 * i, 1'b0);
    end
    check("run fork_cnt", 32'(fork_cnt), 0);
    check("run corr_cnt", 32'(corr_cnt), 0);

    // Fork at pc = 8
    fork_req = 1; fork_bta = 100;
    step();
    check_pcs("fork", 100, 10, 1'b1);
    check("fork fork_cnt", 32'(fork_cnt), 1);
    fork_bta = 200;
    step();
    check_pcs("fork2", 102, 12, 1'b1);
    check("fork2 fork_cnt", 32'(fork_cnt), 1);
    fork_req = 0;
    step();
    check_pcs("forked run", 104, 14, 1'b1);

    // Taken resolution
    correct_en_n = 1; correction_n = 102;
    step();
    check_pcs("resolve", 106, 102, 1'b0);
    check("resolve corr_cnt", 32'(corr_cnt), 1);
    clear_inputs();

    // Stall blocks fork, correction still applies
    stall = 1; fork_req = 1; fork_bta = 300;
    step();
    check_pcs("stall fork", 106, 102, 1'b0);
    check("stall fork_cnt", 32'(fork_cnt), 1);
    correct_en_t = 1; correction_t = 40;
    step();
    check_pcs("stall corr", 40, 102, 1'b0);
    check("stall corr_cnt", 32'(corr_cnt), 2);
    clear_inputs();
    step();
    check_pcs("unstall", 42, 104, 1'b0);

    // Correction and fork same cycle
    fork_req = 1; fork_bta = 500; correct_en_n = 1; correction_n = 50;
    step();
    check_pcs("corr+fork", 44, 50, 1'b0);
    check("corr+fork fork_cnt", 32'(fork_cnt), 1);
    check("corr+fork corr_cnt", 32'(corr_cnt), 3);
    clear_inputs();

    // Dual correction
    correct_en_t = 1; correction_t = 1020; correct_en_n = 1; correction_n = 1022;
    step();
    check_pcs("dual", 1020, 1022, 1'b0);
    check("dual err", 32'(err), 1);
    check("dual corr_cnt", 32'(corr_cnt), 4);
    clear_inputs();
    step();
    check_pcs("wrap", 1022, 0, 1'b0);
    check("wrap err", 32'(err), 1);
    step();
    check_pcs("wrap2", 0, 2, 1'b0);
    check("err sticky", 32'(err), 1);

    // Saturation: 19 more correction cycles starting from corr_cnt = 4
    correct_en_t = 1; correction_t = 7;
    for (int i = 0; i < 10; i++) step();
    check("sat mid corr_cnt", 32'(corr_cnt), 14);
    check("sat mid pc_n", 32'(pc_n), 22);
    for (int i = 0; i < 9; i++) step();
    check("sat corr_cnt", 32'(corr_cnt), 15);
    check_pcs("sat", 7, 40, 1'b0);
    clear_inputs();

    // Async reset in FORKED
    fork_req = 1; fork_bta = 600;
    step();
    check_pcs("fork again", 600, 42, 1'b1);
    check("fork again fork_cnt", 32'(fork_cnt), 2);
    clear_inputs();
    #2 rst = 0;
    #1;
    check_reset_vals("async reset");
    rst = 1;
    step();
    check_pcs("post reset", 2, 2, 1'b0);
    check("post reset fork_cnt", 32'(fork_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
